// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Resolves next-PC across exception, branch, interrupt, jump, stall and sequential fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0008,
    parameter logic [31:0] NOP        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    input  logic        irq,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] epc
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        irq_take;
    logic        redirect;

    // Sequential increment never touches the kernel bit; the low 31 bits wrap.
    assign pc_plus4  = {pc[31], pc[30:0] + 31'd4};
    assign inst_addr = pc;

    // Interrupts are masked in kernel mode and yield to any older redirect.
    assign irq_take = irq & ~pc[31] & ~exc_req & ~branch_taken;
    assign redirect = exc_req | branch_taken | irq_take | jump;

    always_comb begin
        next_pc = pc_plus4;
        if (exc_req)
            next_pc = EXC_VECTOR;
        else if (branch_taken)
            next_pc = branch_target;
        else if (irq_take)
            next_pc = IRQ_VECTOR;
        else if (jump)
            next_pc = {jump_target[31:2], 2'b00};
        else if (stall)
            next_pc = pc;
    end

    // if_id_valid=1 marks a real fetched word; stall freezes the register, a redirect flushes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_inst     <= NOP;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            epc            <= 32'h0;
        end else begin
            pc <= next_pc;
            if (redirect) begin
                if_id_inst     <= NOP;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b0;
            end else if (!stall) begin
                if_id_inst     <= inst_data;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
            end
            if (irq_take)
                epc <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against an event-priority reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        exc_req = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] epc;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [31:0] m_pc, m_inst, m_pp4, m_epc;
    logic        m_valid;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target), .exc_req(exc_req),
        .irq(irq), .inst_addr(inst_addr), .inst_data(inst_data), .if_id_inst(if_id_inst),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .epc(epc)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h00C3};
    endfunction

    assign inst_data = rom(inst_addr);

    function automatic logic [31:0] seq_pc(input logic [31:0] p);
        logic [31:0] low;
        low = (p + 32'd4) & 32'h7FFF_FFFF;
        return (p & 32'h8000_0000) | low;
    endfunction

    // Advance one edge: model decides the event that wins this cycle, then the clock ticks.
    task automatic tick();
        logic [31:0] n_pc, n_inst, n_pp4, n_epc;
        logic        n_valid, interrupt, flush;
        interrupt = irq && (m_pc < 32'h8000_0000) && !exc_req && !branch_taken;
        flush = exc_req || branch_taken || interrupt || jump;
        n_epc = interrupt ? m_pc : m_epc;
        if (exc_req)           n_pc = 32'h8000_0008;
        else if (branch_taken) n_pc = branch_target;
        else if (interrupt)    n_pc = 32'h8000_0004;
        else if (jump)         n_pc = jump_target & ~32'h3;
        else if (stall)        n_pc = m_pc;
        else                   n_pc = seq_pc(m_pc);
        if (flush) begin
            n_inst = 32'h0; n_pp4 = seq_pc(m_pc); n_valid = 1'b0;
        end else if (stall) begin
            n_inst = m_inst; n_pp4 = m_pp4; n_valid = m_valid;
        end else begin
            n_inst = rom(m_pc); n_pp4 = seq_pc(m_pc); n_valid = 1'b1;
        end
        if (reset) begin
            n_pc = 32'h8000_0000; n_inst = 32'h0; n_pp4 = 32'h0; n_valid = 1'b0; n_epc = 32'h0;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_inst = n_inst; m_pp4 = n_pp4; m_valid = n_valid; m_epc = n_epc;
    endtask

    task automatic clear_inputs();
        stall = 0; jump = 0; branch_taken = 0; exc_req = 0; irq = 0; reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; stall = 1; jump = 1; jump_target = 32'h0000_0700; irq = 1;
        tick(); tick();
        tests_run++;
        if (inst_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL reset_pc got %h want %h", inst_addr, 32'h8000_0000); end
        tests_run++;
        if ({if_id_inst, if_id_pc_plus4, epc} !== 96'h0 || if_id_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_regs got inst=%h pp4=%h epc=%h v=%b want zeros", if_id_inst, if_id_pc_plus4, epc, if_id_valid);
        end
        clear_inputs();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'h8000_0000 + 32'(i * 4);
            tests_run++;
            if (inst_addr !== a) begin tests_failed++; $display("FAIL seq_addr%0d got %h want %h", i, inst_addr, a); end
            tick();
            tests_run++;
            if (if_id_inst !== rom(a) || if_id_valid !== 1'b1 || if_id_pc_plus4 !== a + 32'd4) begin
                tests_failed++;
                $display("FAIL seq_ifid%0d got %h/%h/%b want %h/%h/1", i, if_id_inst, if_id_pc_plus4, if_id_valid, rom(a), a + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (inst_addr !== 32'h8000_0010 || if_id_inst !== rom(32'h8000_000C) || if_id_valid !== 1'b1
                || if_id_pc_plus4 !== 32'h8000_0010) begin
                tests_failed++;
                $display("FAIL stall_hold%0d got addr=%h inst=%h pp4=%h want addr=80000010 inst=%h pp4=80000010",
                         i, inst_addr, if_id_inst, if_id_pc_plus4, rom(32'h8000_000C));
            end
        end
        stall = 0;
        tick();
        tests_run++;
        if (inst_addr !== 32'h8000_0014 || if_id_inst !== rom(32'h8000_0010)) begin
            tests_failed++;
            $display("FAIL stall_release got addr=%h inst=%h want 80000014/%h", inst_addr, if_id_inst, rom(32'h8000_0010));
        end
        tick();
    endtask

    task automatic test_jump_during_stall();
        stall = 1; jump = 1; jump_target = 32'h0000_0103;
        tick();
        tests_run++;
        if (inst_addr !== 32'h0000_0100 || if_id_inst !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h8000_001C) begin
            tests_failed++;
            $display("FAIL jump_stall got addr=%h inst=%h v=%b pp4=%h want 00000100/0/0/8000001c",
                     inst_addr, if_id_inst, if_id_valid, if_id_pc_plus4);
        end
        clear_inputs();
        tick();
        tests_run++;
        if (if_id_inst !== rom(32'h0000_0100) || if_id_valid !== 1'b1 || inst_addr !== 32'h0000_0104) begin
            tests_failed++;
            $display("FAIL jump_target_fetch got inst=%h v=%b addr=%h want %h/1/00000104", if_id_inst, if_id_valid, inst_addr, rom(32'h100));
        end
    endtask

    task automatic test_branch_vs_jump();
        jump = 1; jump_target = 32'h0000_0040;
        tick();
        jump = 1; jump_target = 32'h0000_0200; branch_taken = 1; branch_target = 32'h0000_0080;
        tick();
        tests_run++;
        if (inst_addr !== 32'h0000_0080 || if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h0000_0044) begin
            tests_failed++;
            $display("FAIL branch_vs_jump got addr=%h v=%b pp4=%h want 00000080/0/00000044", inst_addr, if_id_valid, if_id_pc_plus4);
        end
        clear_inputs();
        tick();
        tests_run++;
        if (if_id_inst !== rom(32'h0000_0080) || if_id_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_fetch got %h/%b want %h/1", if_id_inst, if_id_valid, rom(32'h80));
        end
    endtask

    task automatic test_irq();
        jump = 1; jump_target = 32'h0000_0050;
        tick();
        jump = 0; irq = 1;
        tick();
        tests_run++;
        if (inst_addr !== 32'h8000_0004 || epc !== 32'h0000_0050 || if_id_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_entry got addr=%h epc=%h v=%b want 80000004/00000050/0", inst_addr, epc, if_id_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (inst_addr !== 32'h8000_0008 + 32'(i * 4) || epc !== 32'h0000_0050 || if_id_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL irq_masked%0d got addr=%h epc=%h v=%b want %h/00000050/1",
                         i, inst_addr, epc, if_id_valid, 32'h8000_0008 + 32'(i * 4));
            end
        end
        clear_inputs();
    endtask

    task automatic test_exc_vs_branch();
        jump = 1; jump_target = 32'h0000_0300;
        tick();
        jump = 0; exc_req = 1; branch_taken = 1; branch_target = 32'h0000_1234; irq = 1;
        tick();
        tests_run++;
        if (inst_addr !== 32'h8000_0008 || if_id_valid !== 1'b0 || epc !== 32'h0000_0050) begin
            tests_failed++;
            $display("FAIL exc_vs_branch got addr=%h v=%b epc=%h want 80000008/0/00000050", inst_addr, if_id_valid, epc);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        stall = 1;
        tick(); tick();
        reset = 1; jump = 1; jump_target = 32'h0000_0400;
        tick();
        tests_run++;
        if (inst_addr !== 32'h8000_0000 || if_id_valid !== 1'b0 || epc !== 32'h0 || if_id_inst !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_stall got addr=%h v=%b epc=%h inst=%h pp4=%h want 80000000/0/0/0/0",
                     inst_addr, if_id_valid, epc, if_id_inst, if_id_pc_plus4);
        end
        clear_inputs();
        tick();
        tests_run++;
        if (if_id_valid !== 1'b1 || if_id_inst !== rom(32'h8000_0000) || inst_addr !== 32'h8000_0004) begin
            tests_failed++;
            $display("FAIL reset_no_bubble got v=%b inst=%h addr=%h want 1/%h/80000004", if_id_valid, if_id_inst, inst_addr, rom(32'h8000_0000));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 79) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            jump_target   = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_FFFF) : $urandom;
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = $urandom & 32'h7FFF_FFFC;
            exc_req       = ($urandom_range(0, 29) == 0);
            irq           = ($urandom_range(0, 4) == 0);
            #1;
            tests_run++;
            if (inst_addr !== m_pc) begin tests_failed++; $display("FAIL rand_addr c%0d got %h want %h", i, inst_addr, m_pc); end
            tick();
            tests_run++;
            if (if_id_inst !== m_inst || if_id_pc_plus4 !== m_pp4 || if_id_valid !== m_valid || epc !== m_epc) begin
                tests_failed++;
                $display("FAIL rand_regs c%0d got %h/%h/%b/%h want %h/%h/%b/%h", i,
                         if_id_inst, if_id_pc_plus4, if_id_valid, epc, m_inst, m_pp4, m_valid, m_epc);
            end
        end
        clear_inputs();
    endtask

    initial begin
        m_pc = 32'h8000_0000; m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_epc = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_jump_during_stall();
        test_branch_vs_jump();
        test_irq();
        test_exc_vs_branch();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
